// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU result path: function-select codes, the
// writeback op encoding and the packed queue entry carried from the ALU
// output stage into alu_result_sink.
package alu_pkg;

  localparam logic [4:0] FS_SLL  = 5'h0C;
  localparam logic [4:0] FS_SRL  = 5'h0D;
  localparam logic [4:0] FS_SRA  = 5'h0E;
  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  typedef enum logic [1:0] {
    OP_WB   = 2'b00,  // ALU result to register file
    OP_MFHI = 2'b01,  // copy architectural HI to register file
    OP_MFLO = 2'b10,  // copy architectural LO to register file
    OP_NOWR = 2'b11   // flags only, no register write
  } op_e;

  // 2 + 5 + 5 + 32 + 32 + 4 = 80 bits
  typedef struct packed {
    op_e         op;
    logic [4:0]  fs;
    logic [4:0]  dest;
    logic [31:0] y_hi;
    logic [31:0] y_lo;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } res_entry_t;

  // MULT and DIV produce a 64-bit HI:LO result rather than a register value.
  function automatic logic is_muldiv(input logic [4:0] fs);
    return (fs == FS_MULT) || (fs == FS_DIV);
  endfunction

endpackage

// File: rtl/alu_result_sink_res_fifo.sv
// res_fifo
// In-order result queue with a registered occupancy count.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (clears pointers/count)
//   push         write wr_data at the tail (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   wr_data      entry to enqueue
//   head         entry at the head of the queue (valid when !empty)
//   full, empty  derived from the registered count only
module res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  res_entry_t wr_data,
  output res_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  res_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_sink.sv
// alu_result_sink
// Receiving end of the ALU result bus. Results are queued in order and
// retired one per cycle, updating HI/LO, the {C,V,N,Z} status register and
// the single register-file write port.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        result handshake; in_ready = queue not full
//   in_op, in_fs, in_dest      writeback op, producing function, destination
//   in_y_hi, in_y_lo           ALU result words
//   in_c, in_v, in_n, in_z     ALU flags
//   wb_stall                   register file cannot take a write this cycle
//   rf_we, rf_addr, rf_wdata   registered register-file write port
//   hi_q, lo_q                 architectural HI / LO
//   flags_q                    {C,V,N,Z}
//   retire_cnt                 entries retired since reset (wraps)
module alu_result_sink
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_fs,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_y_hi,
  input  logic [31:0] in_y_lo,
  input  logic        in_c,
  input  logic        in_v,
  input  logic        in_n,
  input  logic        in_z,
  input  logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [3:0]  flags_q,
  output logic [31:0] retire_cnt
);

  res_entry_t  in_entry;
  res_entry_t  head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        head_md;
  logic        wr_req;
  logic        hilo_upd;
  logic        flag_upd;
  logic [31:0] wr_data;

  assign in_entry = '{op: op_e'(in_op), fs: in_fs, dest: in_dest,
                      y_hi: in_y_hi, y_lo: in_y_lo,
                      c: in_c, v: in_v, n: in_n, z: in_z};

  // in_ready comes straight from the registered count, so a pop on the same
  // edge never opens the queue combinationally.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !wb_stall;

  res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_entry),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Retire decode of the head entry.
  always_comb begin
    head_md  = is_muldiv(head.fs);
    wr_req   = 1'b0;
    hilo_upd = 1'b0;
    flag_upd = 1'b0;
    wr_data  = head.y_lo;
    unique case (head.op)
      OP_WB: begin
        wr_req   = !head_md;
        hilo_upd = head_md;
        flag_upd = 1'b1;
      end
      OP_MFHI: begin
        wr_req  = 1'b1;
        wr_data = hi_q;
      end
      OP_MFLO: begin
        wr_req  = 1'b1;
        wr_data = lo_q;
      end
      OP_NOWR: begin
        hilo_upd = head_md;
        flag_upd = 1'b1;
      end
      default: ;
    endcase
  end

  // Retire stage: outputs registered off the head at the popping edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      flags_q    <= '0;
      retire_cnt <= '0;
    end else begin
      rf_we      <= 1'b0;
      // Assigned every edge (adding zero when idle) so the value always
      // reflects the register contents.
      retire_cnt <= retire_cnt + 32'(pop);
      if (pop) begin
        // Register $zero is never written.
        if (wr_req && (head.dest != 5'd0)) begin
          rf_we    <= 1'b1;
          rf_addr  <= head.dest;
          rf_wdata <= wr_data;
        end
        if (hilo_upd) begin
          hi_q <= head.y_hi;
          lo_q <= head.y_lo;
        end
        // MULT/DIV leave C undefined on the ALU side, so the old C is kept.
        if (flag_upd) begin
          flags_q <= {(head_md ? flags_q[3] : head.c), head.v, head.n, head.z};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_sink.sv
module tb_alu_result_sink;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_fs = 5'd0;
  logic [4:0]  in_dest = 5'd0;
  logic [31:0] in_y_hi = 32'd0;
  logic [31:0] in_y_lo = 32'd0;
  logic        in_c = 1'b0;
  logic        in_v = 1'b0;
  logic        in_n = 1'b0;
  logic        in_z = 1'b0;
  logic        wb_stall = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [3:0]  flags_q;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_sink #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_fs      (in_fs),
    .in_dest    (in_dest),
    .in_y_hi    (in_y_hi),
    .in_y_lo    (in_y_lo),
    .in_c       (in_c),
    .in_v       (in_v),
    .in_n       (in_n),
    .in_z       (in_z),
    .wb_stall   (wb_stall),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .hi_q       (hi_q),
    .lo_q       (lo_q),
    .flags_q    (flags_q),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [1:0] op, input logic [4:0] fs, input logic [4:0] dest,
                        input logic [31:0] yhi, input logic [31:0] ylo, input logic [3:0] cvnz);
    in_valid = 1'b1;
    in_op    = op;
    in_fs    = fs;
    in_dest  = dest;
    in_y_hi  = yhi;
    in_y_lo  = ylo;
    {in_c, in_v, in_n, in_z} = cvnz;
  endtask

  task automatic test_reset();
    logic saw_we;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %h want 0", rf_addr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
    n_checks++; if (hi_q !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_q); end
    n_checks++; if (lo_q !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_q); end
    n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags_q); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", retire_cnt); end

    // Two entries queued behind a stall, then reset drops them.
    wb_stall = 1'b1;
    set_in(OP_WB, 5'h00, 5'd5, 32'd0, 32'h11, 4'b0000);
    @(negedge clk);
    set_in(OP_WB, 5'h00, 5'd6, 32'd0, 32'h22, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_full: got in_ready %b want 0", in_ready); end
    reset = 1'b1;
    @(negedge clk);
    wb_stall = 1'b0;
    saw_we = rf_we;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rf_we) saw_we = 1'b1;
    end
    n_checks++; if (saw_we !== 1'b0) begin n_fail++; $display("FAIL midreset_no_we: got %b want 0", saw_we); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset_cnt: got %h want 0", retire_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    set_in(OP_WB, 5'h00, 5'd8, 32'd0, 32'h0000_0005, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %b want 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd8) begin n_fail++; $display("FAIL add_addr: got %0d want 8", rf_addr); end
    n_checks++; if (rf_wdata !== 32'd5) begin n_fail++; $display("FAIL add_data: got %h want 5", rf_wdata); end
    n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b want 0000", flags_q); end
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL add_cnt: got %0d want 1", retire_cnt); end
    // Same result to $zero, carrying C=1 so a later MULT can show C is held.
    set_in(OP_WB, 5'h00, 5'd0, 32'd0, 32'h0000_0007, 4'b1000);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL add_we_drop: got %b want 0", rf_we); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_dest_we: got %b want 0", rf_we); end
    n_checks++; if (retire_cnt !== 32'd2) begin n_fail++; $display("FAIL zero_dest_cnt: got %0d want 2", retire_cnt); end
    n_checks++; if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL zero_dest_flags: got %b want 1000", flags_q); end
  endtask

  task automatic test_mult_mfhi();
    // ALU leaves C undefined for MULT; drive the opposite of the prior C.
    set_in(OP_WB, FS_MULT, 5'd9, 32'h0000_0001, 32'h8000_0000, 4'b0000);
    @(negedge clk);
    set_in(OP_MFHI, 5'h10, 5'd3, 32'hDEAD_DEAD, 32'hBEEF_BEEF, 4'b0101);
    @(negedge clk);
    set_in(OP_MFLO, 5'h12, 5'd4, 32'hDEAD_DEAD, 32'hBEEF_BEEF, 4'b0110);
    n_checks++; if (hi_q !== 32'h0000_0001) begin n_fail++; $display("FAIL mult_hi: got %h want 00000001", hi_q); end
    n_checks++; if (lo_q !== 32'h8000_0000) begin n_fail++; $display("FAIL mult_lo: got %h want 80000000", lo_q); end
    n_checks++; if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL mult_flags: got %b want 1000", flags_q); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mult_no_write: got %b want 0", rf_we); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL mfhi_we: got %b want 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd3) begin n_fail++; $display("FAIL mfhi_addr: got %0d want 3", rf_addr); end
    n_checks++; if (rf_wdata !== 32'h0000_0001) begin n_fail++; $display("FAIL mfhi_data: got %h want 00000001", rf_wdata); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL mflo_we: got %b want 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd4) begin n_fail++; $display("FAIL mflo_addr: got %0d want 4", rf_addr); end
    n_checks++; if (rf_wdata !== 32'h8000_0000) begin n_fail++; $display("FAIL mflo_data: got %h want 80000000", rf_wdata); end
    n_checks++; if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL mfxx_flags: got %b want 1000", flags_q); end
    n_checks++; if (retire_cnt !== 32'd5) begin n_fail++; $display("FAIL mult_cnt: got %0d want 5", retire_cnt); end
  endtask

  task automatic test_stall();
    int   k = 0;
    int   r = 0;
    logic acc;
    for (int cyc = 0; cyc < 12; cyc++) begin
      wb_stall = (cyc < 4);
      if (k < 3) set_in(OP_WB, 5'h00, 5'(10 + k), 32'd0, 32'(10 + k), 4'b0000);
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) k++;
      if (rf_we) begin
        n_checks++; if (rf_addr !== 5'(10 + r)) begin n_fail++; $display("FAIL stall_order_addr: got %0d want %0d", rf_addr, 10 + r); end
        n_checks++; if (rf_wdata !== 32'(10 + r)) begin n_fail++; $display("FAIL stall_order_data: got %h want %h", rf_wdata, 10 + r); end
        r++;
      end
      if (cyc == 1) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", in_ready); end
      end
      if (cyc == 3) begin
        n_checks++; if (k !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d want 2", k); end
        n_checks++; if (r !== 0) begin n_fail++; $display("FAIL stall_retired: got %0d want 0", r); end
        n_checks++; if (rf_addr !== 5'd4) begin n_fail++; $display("FAIL stall_addr_hold: got %0d want 4", rf_addr); end
        n_checks++; if (rf_wdata !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_data_hold: got %h want 80000000", rf_wdata); end
      end
    end
    n_checks++; if (r !== 3) begin n_fail++; $display("FAIL stall_total_retired: got %0d want 3", r); end
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL stall_total_accepted: got %0d want 3", k); end
    n_checks++; if (retire_cnt !== 32'd8) begin n_fail++; $display("FAIL stall_cnt: got %0d want 8", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] sb[$];
    logic [36:0] exp_e;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] start_cnt;
    logic        do_push;
    logic        do_pop;
    int pushed = 0;
    int popped = 0;
    int mcnt = 0;
    int cyc = 0;
    start_cnt = retire_cnt;
    while ((pushed < 100 || mcnt > 0) && cyc < 3000) begin
      wb_stall = (pushed < 100) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (pushed < 100 && $urandom_range(0, 3) != 0) begin
        dest = 5'($urandom_range(1, 31));
        data = $urandom;
        set_in(OP_WB, 5'($urandom_range(0, 29)), dest, $urandom, data, 4'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      n_checks++; if (in_ready !== (mcnt < 2)) begin n_fail++; $display("FAIL b2b_ready: got %b want %b (occupancy %0d)", in_ready, (mcnt < 2), mcnt); end
      do_push = in_valid && (mcnt < 2);
      do_pop  = (mcnt > 0) && !wb_stall;
      if (do_push) sb.push_back({dest, data});
      @(negedge clk);
      if (do_push) begin mcnt++; pushed++; end
      if (do_pop) mcnt--;
      if (rf_we) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_extra_write: got addr %0d data %h want none", rf_addr, rf_wdata);
        end else begin
          exp_e = sb.pop_front();
          n_checks++; if ({rf_addr, rf_wdata} !== exp_e) begin n_fail++; $display("FAIL b2b_entry: got %h_%h want %h_%h", rf_addr, rf_wdata, exp_e[36:32], exp_e[31:0]); end
          popped++;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    n_checks++; if (cyc >= 3000) begin n_fail++; $display("FAIL b2b_timeout: got %0d cycles want < 3000", cyc); end
    n_checks++; if (popped !== 100) begin n_fail++; $display("FAIL b2b_popped: got %0d want 100", popped); end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d want 0", sb.size()); end
    n_checks++; if (retire_cnt !== start_cnt + 32'd100) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", retire_cnt, start_cnt + 32'd100); end
  endtask

  task automatic test_wrap();
    in_valid = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_cnt;
    n_checks++; if (retire_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", retire_cnt); end
    set_in(OP_NOWR, 5'h00, 5'd7, 32'd0, 32'd5, 4'b0101);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0", retire_cnt); end
    n_checks++; if (flags_q !== 4'b0101) begin n_fail++; $display("FAIL nowr_flags: got %b want 0101", flags_q); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL nowr_we: got %b want 0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult_mfhi();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
